// File: rtl/b_ram_ctrl.sv
// Load/compute sequencer for the dual-bank B_RAM: fills bank A (matrix) then bank B (vector)
// from one stream, then walks every (row, col) pair into the MAC with 1-cycle read latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; no RAM access
// LOAD_A  | streaming matrix words into bank A, row-major
// LOAD_B  | streaming vector words into bank B; final word must carry s_last
// COMPUTE | issuing paired reads whenever the output slot is free
// DRAIN   | last pair presented, waiting for the MAC to take it
// DONE    | one-cycle completion pulse
module b_ram_ctrl #(
  parameter int width        = 8,
  parameter int depth_bits_a = 6,
  parameter int depth_bits_b = 3
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 start,
  input  logic [width-1:0]                     s_data,
  input  logic                                 s_valid,
  input  logic                                 s_last,
  output logic                                 s_ready,
  output logic                                 write_ena,
  output logic                                 write_enb,
  output logic [depth_bits_a-1:0]              write_addra,
  output logic [depth_bits_b-1:0]              write_addrb,
  output logic [width-1:0]                     write_dia,
  output logic [width-1:0]                     write_dib,
  output logic                                 read_ena,
  output logic                                 read_enb,
  output logic [depth_bits_a-1:0]              read_addra,
  output logic [depth_bits_b-1:0]              read_addrb,
  output logic                                 mac_valid,
  input  logic                                 mac_ready,
  output logic                                 mac_first,
  output logic                                 mac_last,
  output logic [depth_bits_a-depth_bits_b-1:0] mac_row,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  // ROWS*COLS-1 and COLS-1 are both all-ones in their counter widths
  localparam logic [depth_bits_a-1:0] LAST_WORD = '1;
  localparam logic [depth_bits_b-1:0] LAST_COL  = '1;

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, DONE
  } state_t;

  state_t                  state;
  logic [depth_bits_a-1:0] wr_cnt;
  logic [depth_bits_a-1:0] rd_cnt;
  logic                    issue;

  assign s_ready     = (state == LOAD_A) || (state == LOAD_B);
  assign write_ena   = (state == LOAD_A) && s_valid;
  assign write_enb   = (state == LOAD_B) && s_valid;
  assign write_addra = wr_cnt;
  assign write_addrb = wr_cnt[depth_bits_b-1:0];
  assign write_dia   = s_data;
  assign write_dib   = s_data;

  // A new read may only land when the output slot is empty or being consumed
  assign issue       = (state == COMPUTE) && (!mac_valid || mac_ready);
  assign read_ena    = issue;
  assign read_enb    = issue;
  assign read_addra  = rd_cnt;
  assign read_addrb  = rd_cnt[depth_bits_b-1:0];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      mac_row   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD_A;
            wr_cnt <= '0;
            rd_cnt <= '0;
            err    <= 1'b0;
          end
        end
        LOAD_A: begin
          if (s_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
            end else if (wr_cnt == LAST_WORD) begin
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (s_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt[depth_bits_b-1:0] == LAST_COL) begin
              if (s_last) begin
                state <= COMPUTE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end else if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end
        COMPUTE: begin
          if (issue) begin
            rd_cnt    <= rd_cnt + 1'b1;
            mac_valid <= 1'b1;
            mac_first <= (rd_cnt[depth_bits_b-1:0] == '0);
            mac_last  <= (rd_cnt[depth_bits_b-1:0] == LAST_COL);
            mac_row   <= rd_cnt[depth_bits_a-1:depth_bits_b];
            if (rd_cnt == LAST_WORD) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mac_valid || mac_ready) begin
            mac_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b_ram_ctrl.sv
// Directed bench for b_ram_ctrl on a 2x2 matrix with a behavioural B_RAM; expected operand
// pairs are queued when a job is loaded and popped as the MAC side consumes them.
module tb_b_ram_ctrl;

  localparam int WD = 8;
  localparam int DA = 2;
  localparam int DB = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [WD-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          write_ena, write_enb;
  logic [DA-1:0] write_addra;
  logic [DB-1:0] write_addrb;
  logic [WD-1:0] write_dia, write_dib;
  logic          read_ena, read_enb;
  logic [DA-1:0] read_addra;
  logic [DB-1:0] read_addrb;
  logic          mac_valid;
  logic          mac_ready;
  logic          mac_first, mac_last;
  logic [DA-DB-1:0] mac_row;
  logic          busy, done, err;

  b_ram_ctrl #(.width(WD), .depth_bits_a(DA), .depth_bits_b(DB)) dut (
    .clk(clk), .aresetn(rst_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .write_ena(write_ena), .write_enb(write_enb),
    .write_addra(write_addra), .write_addrb(write_addrb),
    .write_dia(write_dia), .write_dib(write_dib),
    .read_ena(read_ena), .read_enb(read_enb),
    .read_addra(read_addra), .read_addrb(read_addrb),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .mac_first(mac_first), .mac_last(mac_last), .mac_row(mac_row),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // behavioural B_RAM, one-cycle read latency, contents survive reset
  logic [WD-1:0] mem_a [4];
  logic [WD-1:0] mem_b [2];
  logic [WD-1:0] doa, dob;
  always @(posedge clk) begin
    if (write_ena) mem_a[write_addra] <= write_dia;
    if (write_enb) mem_b[write_addrb] <= write_dib;
    if (read_ena)  doa <= mem_a[read_addra];
    if (read_enb)  dob <= mem_b[read_addrb];
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_valid = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic [18:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MAC-side monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mac_valid) n_valid++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (read_ena || read_enb)
        chk("rd_en_pair", {read_ena, read_enb, write_ena, write_enb}, 4'b1100);
      if (mac_valid && mac_ready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0)
          chk("pair", {doa, dob, mac_row, mac_first, mac_last}, sb.pop_front());
      end
    end
  end

  task automatic push_job(input logic [WD-1:0] w [6]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        sb.push_back({w[r*2+c], w[4+c], 1'(r), 1'(c == 0), 1'(c == 1)});
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [WD-1:0] d, input bit last, input int idx, input bit gap);
    if (gap) begin
      s_valid = 1'b0;
      #1;
      chk("gap_no_write", {write_ena, write_enb}, 0);
      @(posedge clk); #1;
    end
    s_data = d; s_valid = 1'b1; s_last = last;
    #1;
    if (idx < 4)
      chk("wr_a", {write_ena, write_enb, read_ena, s_ready, write_addra, write_dia},
          {4'b1001, 2'(idx), d});
    else
      chk("wr_b", {write_ena, write_enb, read_ena, s_ready, write_addrb, write_dib},
          {4'b0101, 1'(idx - 4), d});
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic load(input logic [WD-1:0] w [6], input bit gap, input int last_at);
    for (int i = 0; i < 6; i++) begin
      send(w[i], i == last_at, i, gap && (i > 0));
      if (i == last_at) break;
    end
  endtask

  task automatic wait_done(input int exp_len, input int exp_pairs, input int v0);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("done_once", n_done - d0, 1);
    if (exp_len >= 0) chk("job_len", done_cyc - start_cyc, exp_len);
    chk("valid_cycles", n_valid - v0, exp_pairs);
    chk("sb_drained", sb.size(), 0);
    chk("end_state", {err, busy, mac_valid}, 3'b000);
  endtask

  logic [WD-1:0] w1 [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
  logic [WD-1:0] w2 [6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
  logic [WD-1:0] w3 [6] = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76};
  logic [WD-1:0] w4 [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
  logic [WD-1:0] w5 [6] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};

  initial begin
    int v0;
    int d0;
    rst_n = 1'b0; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; mac_ready = 1'b1;
    #3;
    chk("rst_vals", {mac_valid, mac_first, mac_last, mac_row, done, err, busy,
                     s_ready, write_ena, write_enb, read_ena, read_enb}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_vals", {mac_valid, done, err, busy, s_ready, read_ena, write_ena}, 0);

    // basic job, full throughput
    v0 = n_valid;
    push_job(w1);
    do_start();
    chk("busy_load", {busy, s_ready}, 2'b11);
    load(w1, 1'b0, 5);
    wait_done(12, 4, v0);

    // MAC backpressure while the second pair (2,6) is presented
    v0 = n_valid;
    push_job(w1);
    do_start();
    load(w1, 1'b0, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mac_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_pair", {mac_valid, doa, dob, mac_row, mac_first, mac_last, read_ena, read_enb},
          {1'b1, 8'd2, 8'd6, 1'b0, 1'b0, 1'b1, 2'b00});
      @(posedge clk); #1;
    end
    mac_ready = 1'b1;
    wait_done(15, 7, v0);

    // stream gaps during load
    v0 = n_valid;
    push_job(w2);
    do_start();
    load(w2, 1'b1, 5);
    wait_done(-1, 4, v0);

    // early s_last on word 3
    v0 = n_valid; d0 = n_done;
    do_start();
    load(w3, 1'b0, 2);
    chk("early_err", {err, busy, s_ready}, 3'b100);
    repeat (3) begin @(posedge clk); #1; end
    chk("early_no_mac", {n_valid - v0, n_done - d0}, 0);
    chk("early_word_written", mem_a[2], 8'h73);
    v0 = n_valid;
    push_job(w4);
    do_start();
    chk("err_cleared", {err, busy}, 2'b01);
    load(w4, 1'b0, 5);
    wait_done(12, 4, v0);

    // missing s_last on the final vector word
    v0 = n_valid; d0 = n_done;
    do_start();
    load(w5, 1'b0, -1);
    chk("missing_last_err", {err, busy, s_ready}, 3'b100);
    repeat (3) begin @(posedge clk); #1; end
    chk("missing_no_mac", {n_valid - v0, n_done - d0}, 0);
    chk("missing_word_written", mem_b[1], 8'h5A);

    // start pulsed during COMPUTE is ignored
    v0 = n_valid;
    push_job(w5);
    do_start();
    load(w5, 1'b0, 5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(12, 4, v0);

    // asynchronous reset mid-COMPUTE, then a fresh job
    d0 = n_done;
    do_start();
    load(w2, 1'b0, 5);
    @(posedge clk); #1;
    chk("pre_rst_valid", mac_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vals", {mac_valid, mac_first, mac_last, mac_row, done, err, busy,
                         s_ready, write_ena, write_enb, read_ena, read_enb}, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_done", n_done - d0, 0);
    v0 = n_valid;
    push_job(w3);
    do_start();
    load(w3, 1'b0, 5);
    wait_done(12, 4, v0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/b_ram_ctrl.md
# b_ram_ctrl

Sequencer for the dual-bank `B_RAM` in the matrix-vector coprocessor. It fills bank A (matrix, row-major) and then bank B (vector) from a single valid/ready input stream. It then walks every (row, col) pair, issuing paired reads to both banks. It presents each operand pair to the downstream MAC with row and first/last markers. It owns every `B_RAM` port; no other block drives the RAM.

## Interface
Parameters (derived: COLS = 2**depth_bits_b, ROWS = 2**(depth_bits_a-depth_bits_b); depth_bits_a > depth_bits_b required):
- width, 8, data bits per word (matches `B_RAM`)
- depth_bits_a, 6, bank A address bits (ROWS*COLS matrix words)
- depth_bits_b, 3, bank B address bits (COLS vector words)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock, shared with `B_RAM`
- aresetn  in  1  asynchronous active-low reset
- start  in  1  begin a load+compute job; sampled only in IDLE
- s_data  in  width  input stream word
- s_valid  in  1  stream word valid
- s_last  in  1  marks final word of the job (final B word)
- s_ready  out  1  stream accept
- write_ena, write_enb  out  1  `B_RAM` write enables
- write_addra  out  depth_bits_a  bank A write address
- write_addrb  out  depth_bits_b  bank B write address
- write_dia, write_dib  out  width  write data (= s_data)
- read_ena, read_enb  out  1  `B_RAM` read enables (always equal)
- read_addra  out  depth_bits_a  bank A read address = {row, col}
- read_addrb  out  depth_bits_b  bank B read address = col
- mac_valid  out  1  read_doa/read_dob hold a valid operand pair
- mac_ready  in  1  MAC consumes pair when mac_valid && mac_ready
- mac_first, mac_last  out  1  pair is col 0 / col COLS-1 of its row
- mac_row  out  depth_bits_a-depth_bits_b  row index of presented pair
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, job complete
- err  out  1  sticky length error, cleared by next accepted start

## Operation
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, DONE.
- IDLE: s_ready=0. start=1 -> LOAD_A, clear counters and err.
- LOAD_A: s_ready=1; write_ena = s_valid (combinational), write_addra = word counter, write_dia = s_data. The counter increments per accepted word. After word ROWS*COLS-1 is accepted -> LOAD_B.
- LOAD_B: same on bank B with counter 0..COLS-1. Final word with s_last=1 -> COMPUTE.
- Length errors: s_last=1 on any earlier word, or s_last=0 on the final B word, sets err and returns to IDLE with no compute. The offending word is still written.
- COMPUTE: issue = !mac_valid || mac_ready. When issue is high, read_ena=read_enb=1 at the current (row, col), then col increments; on col wrap, row increments. Issuing the pair (ROWS-1, COLS-1) -> DRAIN.
- DRAIN: no reads. Last pair consumed -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Write enables are never high in COMPUTE/DRAIN, and read enables are never high in LOAD. `B_RAM` write-over-read priority is therefore never exercised.
- Stall: with mac_ready=0 and mac_valid=1, no read is issued. `B_RAM` holds read_doa/read_dob, so the pair stays stable.
- start outside IDLE is ignored. Stream words in IDLE/COMPUTE/DRAIN/DONE are not accepted.

## Timing
- Reset: state IDLE, all counters 0. Reset values: mac_valid=0, mac_first=0, mac_last=0, mac_row=0, done=0, err=0, busy=0. s_ready and all RAM enables are 0 (they are combinational from state). RAM contents are not cleared.
- Reset mid-job aborts immediately to IDLE. No done pulse.
- Read latency is 1: an issue on edge t makes mac_valid, mac_first, mac_last and mac_row valid after edge t, aligned with RAM data. These outputs are registered on issue.
- mac_valid clears on the consume edge if no new issue occurs.
- Throughput with s_valid and mac_ready held high: one word per cycle for load, one pair per cycle for compute.
- Job length with full throughput: 1 (start) + ROWS*COLS + COLS load + ROWS*COLS compute + 1 DRAIN + 1 DONE cycles.

## Test plan
- Basic job (width=8, depth_bits_a=2, depth_bits_b=1): stream 1,2,3,4,5,6 with s_last on 6, mac_ready=1 -> pairs (1,5),(2,6),(3,5),(4,6) on consecutive cycles. mac_row=0,0,1,1; mac_first=1,0,1,0; mac_last=0,1,0,1; done pulses once; err=0.
- MAC backpressure: same job with mac_ready low for 3 cycles while the pair (2,6) is presented -> (2,6) held stable, no read enables asserted, sequence resumes unchanged.
- Stream gaps: s_valid toggling 1,0,1,0 during load -> write enables only on valid cycles, addresses contiguous 0..3 in bank A and 0..1 in bank B, compute results identical.
- Early s_last on word 3 -> err=1, return to IDLE, no mac_valid, no done. Next start clears err and a correct job passes.
- Missing s_last on word 6 -> err=1, no compute. start pulsed during COMPUTE -> ignored.
- Reset asserted mid-COMPUTE -> all outputs at reset values asynchronously. A new job after reset runs to completion.
